vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port arbiter for the 16 KB screen RAM, shared by the video fetch engine and the Z80 (0x4000–0x7FFF window). Video owns the RAM on every cycle it flags `vfetch`. The CPU is granted single-cycle accesses only in cycles where video does not need the RAM. While a CPU request is blocked, the block drives `cpuWait` (memory contention) and counts the stalled cycles for debug.

## Interface
- No parameters.
- `clock`  in  1  system clock; all state updates on negedge, same edge as the video engine.
- `reset`  in  1  synchronous, active-low reset.
- `vfetch`  in  1  video owns the RAM this cycle.
- `vidA`  in  13  video fetch address (bitmap/attribute offset within screen RAM).
- `vidD`  out  8  RAM read data returned to video; equals `ramDo`, combinational.
- `cpuReq`  in  1  CPU access request; level, held until `cpuAck`.
- `cpuWr`  in  1  1 = write, 0 = read; stable while `cpuReq` is high.
- `cpuA`  in  14  CPU address within the 16 KB bank.
- `cpuDo`  in  8  CPU write data.
- `cpuDi`  out  8  registered CPU read data.
- `cpuAck`  out  1  one-cycle completion pulse.
- `cpuWait`  out  1  request pending but blocked; combinational.
- `ramA`  out  14  RAM address.
- `ramDi`  out  8  RAM write data.
- `ramDo`  in  8  RAM read data; asynchronous, valid in the same cycle as `ramA`.
- `ramWe`  out  1  RAM write enable, active high.
- `stallCount`  out  16  saturating count of cycles with `cpuWait`=1.

## Operation
- FSM states: IDLE, ACK, RELEASE.
- **IDLE:**
  - If `cpuReq`=1 and `vfetch`=0, the cycle is a grant:
    - `ramA`={`cpuA`}; `ramWe`=`cpuWr`; `ramDi`=`cpuDo`.
    - On the clock edge, `cpuDi`<=`ramDo` when reading; `cpuDi` is unchanged when writing.
    - Next state is ACK.
  - If `cpuReq`=1 and `vfetch`=1: `cpuWait`=1, `stallCount` increments, state stays IDLE.
- **ACK:**
  - `cpuAck`=1 for exactly this cycle. No RAM access by the CPU.
  - Next state is RELEASE.
- **RELEASE:**
  - Wait for `cpuReq`=0, then go to IDLE.
  - A request still high is not a new request, so it is never granted twice.
- **Address mux, every cycle:**
  - `vfetch`=1: `ramA`={1'b0,`vidA`} and `ramWe`=0, whatever the FSM state. Video priority is absolute.
  - Otherwise, not granting: `ramA`=`cpuA` and `ramWe`=0.
- `ramWe` is asserted only in a grant cycle. It is never asserted while `vfetch`=1.
- `cpuWait`=`cpuReq` & (state==IDLE) & `vfetch`. It is 0 in ACK and RELEASE.
- `stallCount` is 16-bit. It holds at 0xFFFF and never wraps. It is cleared only by reset.
- A `cpuWr` change while `cpuReq`=1 is illegal; behaviour is undefined.

## Timing
- **Reset values:**
  - state IDLE.
  - `cpuDi`=0x00, `cpuAck`=0, `stallCount`=0.
  - `ramWe`=0 and `cpuWait`=0 while `reset`=0.
  - `ramA` follows the mux.
- **Latency, uncontended** (request seen in a `vfetch`=0 cycle):
  - Grant in that cycle.
  - `cpuAck` and valid `cpuDi` one cycle later.
- **Latency, contended:** the grant happens in the first cycle with `vfetch`=0. Latency is N+1 cycles for N stalled cycles.
- **Simultaneous `cpuReq` rise and `vfetch`=1:** video wins; the stall is counted from that cycle.
- **`vfetch` rising in the cycle after a grant:** no conflict, because the CPU access completed in the grant cycle.
- **Minimum spacing:** IDLE grant → ACK → RELEASE; the next grant is possible 3 cycles after the previous one, provided `cpuReq` dropped on the cycle after ACK.
- **Reset mid-operation:**
  - Any state returns to IDLE; a pending ack is dropped.
  - The CPU must re-request; the bus master handles this because it is reset too.
- `vidD` has no register stage. The video engine samples it on its own load strobes.

## Test plan
- **Uncontended read:** reset; RAM[0x1234]=0xA5; `cpuReq`=1, `cpuWr`=0, `cpuA`=0x1234, `vfetch`=0.
  - Grant cycle: `ramA`=0x1234, `ramWe`=0.
  - Next cycle: `cpuAck`=1, `cpuDi`=0xA5.
  - `stallCount`=0.
- **Contended write:** `vfetch`=1 for 6 cycles; `cpuReq`=1, `cpuWr`=1, `cpuA`=0x0800, `cpuDo`=0x3C raised in the first of those cycles.
  - `cpuWait`=1 for 6 cycles, `ramWe`=0 throughout, `ramA`={0,`vidA`}.
  - 7th cycle: `ramWe`=1, `ramA`=0x0800, `ramDi`=0x3C.
  - 8th cycle: `cpuAck`=1.
  - `stallCount`=6.
- **Held request:** keep `cpuReq` high for 5 cycles after `cpuAck` → exactly one grant and one `cpuAck`; a second `ramWe` pulse never appears.
- **Video priority every cycle:** toggle `vfetch` 1010… with a constant read request. For every cycle with `vfetch`=1, check `ramA`=`vidA` and `ramWe`=0. The grant lands on the first `vfetch`=0 cycle.
- **Saturation:** hold `cpuReq`=1 and `vfetch`=1 for 70000 cycles → `stallCount`=0xFFFF and holds; it does not wrap.
- **Reset mid-operation:** assert `reset`=0 in the ACK cycle → next cycle `cpuAck`=0, `cpuDi`=0x00, `stallCount`=0, state IDLE. A fresh request after release is served normally.

Source files
------------

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Arbitrates the single-port 16 KB screen RAM between the video fetch engine
// and the Z80. Video owns the RAM in every cycle it raises vfetch. The CPU
// gets a single-cycle access only in a cycle where video is idle. While a CPU
// request is blocked, cpuWait is raised and the blocked cycles are counted
// in a saturating debug counter.
//
// All state changes on the falling clock edge, the same edge the video
// engine uses.
//
// Ports
//   clock       in   1   system clock (state updates on negedge)
//   reset       in   1   synchronous, active-low reset
//   vfetch      in   1   video owns the RAM this cycle
//   vidA        in  13   video fetch address within screen RAM
//   vidD        out  8   RAM read data to video (combinational, = ramDo)
//   cpuReq      in   1   CPU request, level, held until cpuAck
//   cpuWr       in   1   1 = write, 0 = read
//   cpuA        in  14   CPU address within the 16 KB bank
//   cpuDo       in   8   CPU write data
//   cpuDi       out  8   registered CPU read data
//   cpuAck      out  1   one-cycle completion pulse
//   cpuWait     out  1   request pending but blocked by video
//   ramA        out 14   RAM address
//   ramDi       out  8   RAM write data
//   ramDo       in   8   RAM read data, valid in the same cycle as ramA
//   ramWe       out  1   RAM write enable, active high
//   stallCount  out 16   saturating count of cycles with cpuWait = 1
// ---------------------------------------------------------------------------
module vram_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        vfetch,
    input  logic [12:0] vidA,
    output logic [7:0]  vidD,
    input  logic        cpuReq,
    input  logic        cpuWr,
    input  logic [13:0] cpuA,
    input  logic [7:0]  cpuDo,
    output logic [7:0]  cpuDi,
    output logic        cpuAck,
    output logic        cpuWait,
    output logic [13:0] ramA,
    output logic [7:0]  ramDi,
    input  logic [7:0]  ramDo,
    output logic        ramWe,
    output logic [15:0] stallCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      nextState_s;
    logic        grant_s;
    logic        stall_s;
    logic [7:0]  cpuDi_r;
    logic        cpuAck_r;
    logic [15:0] stallCount_r;

    // State register: reset returns to IDLE from any state, dropping a pending ack.
    always_ff @(negedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic: RELEASE waits for the request to drop so a held
    // request is never granted a second time.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    nextState_s = ACK;
                end else begin
                    nextState_s = IDLE;
                end
            end
            ACK: begin
                nextState_s = RELEASE;
            end
            RELEASE: begin
                if (!cpuReq) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = RELEASE;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // Output logic: address mux with absolute video priority, grant/stall decode.
    always_comb begin
        grant_s = 1'b0;
        stall_s = 1'b0;
        ramDi   = cpuDo;

        if (vfetch) begin
            ramA = {1'b0, vidA};
        end else begin
            ramA = cpuA;
        end

        // A request is only considered in IDLE and never while reset is held.
        if (reset && (state_r == IDLE) && cpuReq) begin
            if (vfetch) begin
                stall_s = 1'b1;
            end else begin
                grant_s = 1'b1;
            end
        end else begin
            grant_s = 1'b0;
            stall_s = 1'b0;
        end

        // Write strobe exists only in a grant cycle, which implies vfetch = 0.
        ramWe   = grant_s & cpuWr;
        cpuWait = stall_s;
    end

    // Registered CPU-side outputs: read data capture, ack pulse, stall counter.
    always_ff @(negedge clock) begin
        if (!reset) begin
            cpuDi_r      <= 8'h00;
            cpuAck_r     <= 1'b0;
            stallCount_r <= 16'h0000;
        end else begin
            cpuAck_r <= grant_s;
            if (grant_s && !cpuWr) begin
                cpuDi_r <= ramDo;
            end else begin
                cpuDi_r <= cpuDi_r;
            end
            // Saturate at all-ones so a long debug run never wraps to a small value.
            if (stall_s && (stallCount_r != 16'hFFFF)) begin
                stallCount_r <= stallCount_r + 16'd1;
            end else begin
                stallCount_r <= stallCount_r;
            end
        end
    end

    assign vidD       = ramDo;
    assign cpuDi      = cpuDi_r;
    assign cpuAck     = cpuAck_r;
    assign stallCount = stallCount_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Drives the arbiter from a small RAM model and a CPU/video stimulus source.
// Inputs change just after the falling (active) edge; outputs are sampled on
// the rising edge. A cycle-level reference model derives the expected
// outputs from the arbitration rules: a request is served in the first
// video-free cycle, acknowledged one cycle later, and the CPU is locked out
// until it has dropped its request at least two cycles after the grant.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

    logic        clock;
    logic        reset;
    logic        vfetch;
    logic [12:0] vidA;
    logic [7:0]  vidD;
    logic        cpuReq;
    logic        cpuWr;
    logic [13:0] cpuA;
    logic [7:0]  cpuDo;
    logic [7:0]  cpuDi;
    logic        cpuAck;
    logic        cpuWait;
    logic [13:0] ramA;
    logic [7:0]  ramDi;
    logic [7:0]  ramDo;
    logic        ramWe;
    logic [15:0] stallCount;

    logic [7:0]  mem [0:16383];

    int passCnt  = 0;
    int totalCnt = 0;

    // reference model state
    bit          mBlocked;
    int          mGrantCyc;
    int          mCyc;
    bit          mAck;
    logic [7:0]  mDi;
    logic [15:0] mStall;
    bit          nBlocked;
    int          nGrantCyc;
    bit          nAck;
    logic [7:0]  nDi;
    logic [15:0] nStall;
    // expected outputs of the current cycle
    bit          eGrant;
    bit          eWait;
    bit          eWe;
    logic [13:0] eRamA;

    vram_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .vfetch     (vfetch),
        .vidA       (vidA),
        .vidD       (vidD),
        .cpuReq     (cpuReq),
        .cpuWr      (cpuWr),
        .cpuA       (cpuA),
        .cpuDo      (cpuDo),
        .cpuDi      (cpuDi),
        .cpuAck     (cpuAck),
        .cpuWait    (cpuWait),
        .ramA       (ramA),
        .ramDi      (ramDi),
        .ramDo      (ramDo),
        .ramWe      (ramWe),
        .stallCount (stallCount)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    assign ramDo = mem[ramA];

    always @(negedge clock) begin
        if (ramWe === 1'b1) mem[ramA] <= ramDi;
    end

    // Evaluate the model for the cycle whose inputs are currently applied.
    task automatic settle();
        @(posedge clock);
        eRamA = vfetch ? {1'b0, vidA} : cpuA;
        if (reset === 1'b0) begin
            eGrant = 1'b0;
            eWait  = 1'b0;
        end else begin
            eGrant = !mBlocked && cpuReq && !vfetch;
            eWait  = !mBlocked && cpuReq && vfetch;
        end
        eWe = eGrant && cpuWr;
        if (reset === 1'b0) begin
            nBlocked  = 1'b0;
            nAck      = 1'b0;
            nDi       = 8'h00;
            nStall    = 16'h0000;
            nGrantCyc = mGrantCyc;
        end else begin
            nAck      = eGrant;
            nDi       = (eGrant && !cpuWr) ? mem[cpuA] : mDi;
            nStall    = (eWait && mStall != 16'hFFFF) ? mStall + 16'd1 : mStall;
            nGrantCyc = eGrant ? mCyc : mGrantCyc;
            if (eGrant) nBlocked = 1'b1;
            else if (mBlocked && mCyc >= mGrantCyc + 2 && !cpuReq) nBlocked = 1'b0;
            else nBlocked = mBlocked;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        mBlocked  = nBlocked;
        mGrantCyc = nGrantCyc;
        mAck      = nAck;
        mDi       = nDi;
        mStall    = nStall;
        mCyc++;
        #1;
    endtask

    task automatic doReset();
        reset  = 1'b0;
        cpuReq = 1'b0;
        vfetch = 1'b0;
        settle();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        cpuReq = 1'b1;
        cpuWr  = 1'b1;
        cpuA   = 14'h0123;
        cpuDo  = 8'h77;
        vfetch = 1'b0;
        settle();
        totalCnt++;
        if (ramWe !== 1'b0) $display("FAIL reset_ramWe: got %b expected 0", ramWe);
        else passCnt++;
        tick();
        vfetch = 1'b1;
        settle();
        totalCnt++;
        if (cpuWait !== 1'b0) $display("FAIL reset_cpuWait: got %b expected 0", cpuWait);
        else passCnt++;
        totalCnt++;
        if ({cpuAck, cpuDi, stallCount} !== 25'h0)
            $display("FAIL reset_regs: got ack=%b di=%h stall=%h expected 0/00/0000", cpuAck, cpuDi, stallCount);
        else passCnt++;
        totalCnt++;
        if (ramA !== {1'b0, vidA}) $display("FAIL reset_ramA: got %h expected %h", ramA, {1'b0, vidA});
        else passCnt++;
        tick();
        cpuReq = 1'b0;
        reset  = 1'b1;
        settle();
        tick();
    endtask

    task automatic test_uncontended_read();
        doReset();
        mem[14'h1234] <= 8'hA5;
        cpuReq = 1'b1;
        cpuWr  = 1'b0;
        cpuA   = 14'h1234;
        vfetch = 1'b0;
        settle();
        totalCnt++;
        if (ramA !== 14'h1234 || ramWe !== 1'b0)
            $display("FAIL rd_grant: got ramA=%h ramWe=%b expected 1234/0", ramA, ramWe);
        else passCnt++;
        tick();
        settle();
        totalCnt++;
        if (cpuAck !== 1'b1 || cpuDi !== 8'hA5)
            $display("FAIL rd_ack: got ack=%b di=%h expected 1/a5", cpuAck, cpuDi);
        else passCnt++;
        totalCnt++;
        if (stallCount !== 16'h0000) $display("FAIL rd_stall: got %h expected 0000", stallCount);
        else passCnt++;
        tick();
        cpuReq = 1'b0;
        settle();
        tick();
    endtask

    task automatic test_contended_write();
        doReset();
        cpuReq = 1'b1;
        cpuWr  = 1'b1;
        cpuA   = 14'h0800;
        cpuDo  = 8'h3C;
        vfetch = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vidA = 13'($urandom);
            settle();
            totalCnt++;
            if (cpuWait !== 1'b1 || ramWe !== 1'b0 || ramA !== {1'b0, vidA})
                $display("FAIL wr_stall%0d: got wait=%b we=%b ramA=%h expected 1/0/%h", i, cpuWait, ramWe, ramA, {1'b0, vidA});
            else passCnt++;
            tick();
        end
        vfetch = 1'b0;
        settle();
        totalCnt++;
        if (ramWe !== 1'b1 || ramA !== 14'h0800 || ramDi !== 8'h3C || cpuWait !== 1'b0)
            $display("FAIL wr_grant: got we=%b ramA=%h di=%h wait=%b expected 1/0800/3c/0", ramWe, ramA, ramDi, cpuWait);
        else passCnt++;
        tick();
        settle();
        totalCnt++;
        if (cpuAck !== 1'b1 || stallCount !== 16'd6)
            $display("FAIL wr_ack: got ack=%b stall=%0d expected 1/6", cpuAck, stallCount);
        else passCnt++;
        tick();
        cpuReq = 1'b0;
        settle();
        tick();
        totalCnt++;
        if (mem[14'h0800] !== 8'h3C) $display("FAIL wr_mem: got %h expected 3c", mem[14'h0800]);
        else passCnt++;
    endtask

    task automatic test_held_request();
        int weCnt  = 0;
        int ackCnt = 0;
        doReset();
        cpuReq = 1'b1;
        cpuWr  = 1'b1;
        cpuA   = 14'h0456;
        cpuDo  = 8'h99;
        vfetch = 1'b0;
        for (int i = 0; i < 7; i++) begin
            settle();
            if (ramWe === 1'b1) weCnt++;
            if (cpuAck === 1'b1) ackCnt++;
            tick();
        end
        cpuReq = 1'b0;
        settle();
        if (ramWe === 1'b1) weCnt++;
        if (cpuAck === 1'b1) ackCnt++;
        tick();
        totalCnt++;
        if (weCnt != 1 || ackCnt != 1)
            $display("FAIL held_once: got we=%0d ack=%0d expected 1/1", weCnt, ackCnt);
        else passCnt++;
    endtask

    task automatic test_video_priority();
        int ackCnt = 0;
        doReset();
        cpuReq = 1'b1;
        cpuWr  = 1'b0;
        cpuA   = 14'h3ABC;
        for (int i = 0; i < 8; i++) begin
            vfetch = (i % 2 == 0);
            vidA   = 13'($urandom);
            settle();
            if (cpuAck === 1'b1) ackCnt++;
            if (vfetch) begin
                totalCnt++;
                if (ramA !== {1'b0, vidA} || ramWe !== 1'b0)
                    $display("FAIL vprio%0d: got ramA=%h we=%b expected %h/0", i, ramA, ramWe, {1'b0, vidA});
                else passCnt++;
            end else if (i == 1) begin
                totalCnt++;
                if (ramA !== 14'h3ABC || cpuWait !== 1'b0)
                    $display("FAIL vprio_grant: got ramA=%h wait=%b expected 3abc/0", ramA, cpuWait);
                else passCnt++;
            end else if (i == 2) begin
                totalCnt++;
                if (cpuAck !== 1'b1) $display("FAIL vprio_ack: got %b expected 1", cpuAck);
                else passCnt++;
            end
            tick();
        end
        totalCnt++;
        if (ackCnt != 1) $display("FAIL vprio_acks: got %0d expected 1", ackCnt);
        else passCnt++;
        cpuReq = 1'b0;
        settle();
        tick();
    endtask

    task automatic test_reset_mid();
        doReset();
        mem[14'h2222] <= 8'h5A;
        mem[14'h1234] <= 8'hA5;
        cpuReq = 1'b1;
        cpuWr  = 1'b0;
        cpuA   = 14'h2222;
        vfetch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vfetch = (i < 2);
            settle();
            tick();
        end
        // ACK cycle: assert reset here
        reset  = 1'b0;
        vfetch = 1'b1;
        settle();
        totalCnt++;
        if (cpuAck !== 1'b1 || cpuDi !== 8'h5A || stallCount !== 16'd2)
            $display("FAIL mid_ack: got ack=%b di=%h stall=%0d expected 1/5a/2", cpuAck, cpuDi, stallCount);
        else passCnt++;
        tick();
        reset  = 1'b1;
        cpuReq = 1'b0;
        vfetch = 1'b0;
        settle();
        totalCnt++;
        if (cpuAck !== 1'b0 || cpuDi !== 8'h00 || stallCount !== 16'h0000)
            $display("FAIL mid_cleared: got ack=%b di=%h stall=%h expected 0/00/0000", cpuAck, cpuDi, stallCount);
        else passCnt++;
        tick();
        cpuReq = 1'b1;
        cpuA   = 14'h1234;
        settle();
        totalCnt++;
        if (ramA !== 14'h1234 || cpuWait !== 1'b0)
            $display("FAIL mid_regrant: got ramA=%h wait=%b expected 1234/0", ramA, cpuWait);
        else passCnt++;
        tick();
        settle();
        totalCnt++;
        if (cpuAck !== 1'b1 || cpuDi !== 8'hA5)
            $display("FAIL mid_reack: got ack=%b di=%h expected 1/a5", cpuAck, cpuDi);
        else passCnt++;
        tick();
        cpuReq = 1'b0;
        settle();
        tick();
    endtask

    task automatic test_random();
        bit          sawAck = 1'b0;
        logic [56:0] obs;
        logic [56:0] expv;
        int          errs = 0;
        doReset();
        for (int i = 0; i < 2000; i++) begin
            vfetch = 1'($urandom % 2);
            vidA   = 13'($urandom);
            if (!cpuReq) begin
                if ($urandom % 3 == 0) begin
                    cpuReq = 1'b1;
                    cpuWr  = 1'($urandom % 2);
                    cpuA   = 14'($urandom);
                    cpuDo  = 8'($urandom);
                    sawAck = 1'b0;
                end
            end else if (sawAck && ($urandom % 2 == 0)) begin
                cpuReq = 1'b0;
            end
            settle();
            obs  = {ramA, ramWe, cpuWait, cpuAck, cpuDi, stallCount, vidD, (ramWe ? ramDi : 8'h00)};
            expv = {eRamA, eWe, eWait, mAck, mDi, mStall, mem[eRamA], (eWe ? cpuDo : 8'h00)};
            totalCnt++;
            if (obs !== expv) begin
                if (errs < 10) $display("FAIL random cyc %0d: got %h expected %h", i, obs, expv);
                errs++;
            end else passCnt++;
            if (cpuAck === 1'b1) sawAck = 1'b1;
            tick();
        end
        cpuReq = 1'b0;
        settle();
        tick();
    endtask

    task automatic test_saturation();
        doReset();
        cpuReq = 1'b1;
        cpuWr  = 1'b0;
        cpuA   = 14'h0001;
        vfetch = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            settle();
            tick();
        end
        settle();
        totalCnt++;
        if (stallCount !== 16'hFFFF || mStall !== 16'hFFFF)
            $display("FAIL sat_reach: got %h expected ffff", stallCount);
        else passCnt++;
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            tick();
        end
        settle();
        totalCnt++;
        if (stallCount !== 16'hFFFF || cpuWait !== 1'b1)
            $display("FAIL sat_hold: got stall=%h wait=%b expected ffff/1", stallCount, cpuWait);
        else passCnt++;
        tick();
        vfetch = 1'b0;
        settle();
        tick();
        cpuReq = 1'b0;
        settle();
        tick();
    endtask

    initial begin
        reset     = 1'b0;
        vfetch    = 1'b0;
        vidA      = 13'h0000;
        cpuReq    = 1'b0;
        cpuWr     = 1'b0;
        cpuA      = 14'h0000;
        cpuDo     = 8'h00;
        mBlocked  = 1'b0;
        mGrantCyc = 0;
        mCyc      = 0;
        mAck      = 1'b0;
        mDi       = 8'h00;
        mStall    = 16'h0000;
        for (int i = 0; i < 16384; i++) mem[i] <= 8'($urandom);
        #1;
        test_reset();
        test_uncontended_read();
        test_contended_write();
        test_held_request();
        test_video_priority();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
